iob_mem_responder: RTL and testbench

//  Synthesizable memory-side responder for the iob_cache back-end port: accepts
//  mem_valid/mem_addr/mem_wdata/mem_wstrb requests, answers with mem_rdata/mem_ready

---
 rtl/iob_mem_responder_if.sv | 23 ++
 rtl/iob_mem_responder.sv | 103 ++++++++++
 tb/tb_iob_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_mem_responder_if.sv
// Request/response bundle between an iob_cache back-end (master) and its
// memory responder (slave).
interface iob_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  mem_valid;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/iob_mem_responder.sv
// Fixed-latency word memory answering iob_cache back-end requests, with a sticky
// initiator protocol-violation flag and wrapping read/write transaction counters.
module iob_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                reset,
  iob_mem_responder_if.slave  bus,
  output logic                proto_err,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt
);
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 1 << MEM_ADDR_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                ready_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [MEM_ADDR_W-1:0] idx_in;
  logic [MEM_ADDR_W-1:0] idx_q;
  logic                  busy;
  logic                  mismatch;

  assign idx_in   = bus.mem_addr[MEM_ADDR_W+1:2];
  assign idx_q    = addr_q[MEM_ADDR_W+1:2];
  assign busy     = (state == WAIT) || (state == RESP);
  assign mismatch = !bus.mem_valid
                 || (bus.mem_addr  != addr_q)
                 || (bus.mem_wdata != wdata_q)
                 || (bus.mem_wstrb != wstrb_q);

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;

  // Outputs are registered on entry to RESP, so read data is fetched one edge early.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      proto_err <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      case (state)
        IDLE: begin
          if (bus.mem_valid) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            cnt     <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state   <= RESP;
              ready_q <= 1'b1;
              if (bus.mem_wstrb == '0) rdata_q <= mem[idx_in];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= RESP;
            ready_q <= 1'b1;
            if (wstrb_q == '0) rdata_q <= mem[idx_q];
          end
        end
        RESP: begin
          state <= IDLE;
          if (wstrb_q == '0) rd_cnt <= rd_cnt + 16'd1;
          else               wr_cnt <= wr_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
      if (busy && mismatch) proto_err <= 1'b1;
    end
  end

  // Byte-masked commit at the RESP edge; a reset on that edge discards the write.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_iob_mem_responder.sv
// Randomized and directed checks of iob_mem_responder against a word-array
// reference model with byte strobes, address aliasing and transaction counts.
module tb_iob_mem_responder;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int MEM_ADDR_W = 10;
  localparam int LATENCY    = 2;
  localparam int DEPTH      = 1 << MEM_ADDR_W;
  localparam int LIMIT      = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        proto_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  iob_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .proto_err(proto_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] model_mem [DEPTH];
  int exp_rd = 0;
  int exp_wr = 0;

  // Reference: a word array indexed by byte address / 4 modulo depth.
  function automatic logic [31:0] model_access(input logic [31:0] addr,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    int idx;
    idx = int'((addr / 32'd4) % DEPTH);
    if (wstrb == 4'd0) begin
      exp_rd = (exp_rd + 1) % 65536;
      return model_mem[idx];
    end
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    exp_wr = (exp_wr + 1) % 65536;
    return 32'd0;
  endfunction

  // Entered at a falling edge with the DUT idle; returns at the falling edge of
  // the cycle after the response, leaving the request held when hold=1.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit hold,
                        output logic [31:0] rdata, output int lat,
                        output logic ready_after, output int stamp);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.mem_ready !== 1'b1 && lat < LIMIT);
    if (bus.mem_ready !== 1'b1) lat = -1;
    rdata = bus.mem_rdata;
    stamp = cyc;
    @(negedge clk);
    ready_after = bus.mem_ready;
    if (!hold) bus.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.mem_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.mem_ready); end
    tests_run++;
    if (bus.mem_rdata !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.mem_rdata); end
    tests_run++;
    if (proto_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_proto_err: got %b expected 0", proto_err); end
    tests_run++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_counters: got rd=%0d wr=%0d expected 0/0", rd_cnt, wr_cnt); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] rdata, exp;
    logic ra;
    int lat, st;
    exp = model_access(32'h10, 32'hDEADBEEF, 4'hF);
    do_txn(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rdata, lat, ra, st);
    tests_run++;
    if (lat !== LATENCY) begin tests_failed++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, LATENCY); end
    tests_run++;
    if (ra !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_ready_pulse: got %b expected 0", ra); end
    tests_run++;
    if (rdata !== exp) begin tests_failed++; $display("[TB] FAIL wr_rdata_zero: got %h expected %h", rdata, exp); end
    exp = model_access(32'h10, 32'h0, 4'h0);
    do_txn(32'h10, 32'h0, 4'h0, 1'b0, rdata, lat, ra, st);
    tests_run++;
    if (lat !== LATENCY) begin tests_failed++; $display("[TB] FAIL rd_latency: got %0d expected %0d", lat, LATENCY); end
    tests_run++;
    if (rdata !== exp) begin tests_failed++; $display("[TB] FAIL rd_data: got %h expected %h", rdata, exp); end
    tests_run++;
    if (rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr)) begin tests_failed++; $display("[TB] FAIL wr_rd_counters: got rd=%0d wr=%0d expected %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr); end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rdata, exp;
    logic ra;
    int lat, st;
    exp = model_access(32'h10, 32'h00000055, 4'b0001);
    do_txn(32'h10, 32'h00000055, 4'b0001, 1'b0, rdata, lat, ra, st);
    exp = model_access(32'h10, 32'h0, 4'h0);
    do_txn(32'h10, 32'h0, 4'h0, 1'b0, rdata, lat, ra, st);
    tests_run++;
    if (rdata !== exp) begin tests_failed++; $display("[TB] FAIL byte_strobe: got %h expected %h", rdata, exp); end
  endtask

  task automatic test_alias();
    logic [31:0] rdata, exp;
    logic ra;
    int lat, st;
    exp = model_access(32'h1004, 32'h12345678, 4'hF);
    do_txn(32'h1004, 32'h12345678, 4'hF, 1'b0, rdata, lat, ra, st);
    exp = model_access(32'h0007, 32'h0, 4'h0);
    do_txn(32'h0007, 32'h0, 4'h0, 1'b0, rdata, lat, ra, st);
    tests_run++;
    if (rdata !== exp) begin tests_failed++; $display("[TB] FAIL alias_read: got %h expected %h", rdata, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rdata, exp;
    logic [31:0] addrs [3];
    logic ra;
    int lat, st [3];
    int rd0;
    addrs[0] = 32'h10; addrs[1] = 32'h4; addrs[2] = 32'h1010;
    rd0 = exp_rd;
    for (int i = 0; i < 3; i++) begin
      exp = model_access(addrs[i], 32'h0, 4'h0);
      do_txn(addrs[i], 32'h0, 4'h0, i < 2, rdata, lat, ra, st[i]);
      tests_run++;
      if (rdata !== exp) begin tests_failed++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, rdata, exp); end
    end
    for (int i = 1; i < 3; i++) begin
      tests_run++;
      if (st[i] - st[i-1] !== LATENCY + 1) begin tests_failed++; $display("[TB] FAIL b2b_spacing%0d: got %0d expected %0d", i, st[i] - st[i-1], LATENCY + 1); end
    end
    tests_run++;
    if (rd_cnt !== 16'(rd0 + 3)) begin tests_failed++; $display("[TB] FAIL b2b_rd_cnt: got %0d expected %0d", rd_cnt, rd0 + 3); end
  endtask

  task automatic test_proto_drop();
    logic [31:0] rdata, exp;
    logic ra;
    int lat, st;
    tests_run++;
    if (proto_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL proto_pre: got %b expected 0", proto_err); end
    exp = model_access(32'h4, 32'h0, 4'h0);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h4; bus.mem_wdata = '0; bus.mem_wstrb = '0;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h3C;
    @(negedge clk);
    tests_run++;
    if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== exp) begin tests_failed++; $display("[TB] FAIL proto_drop_resp: got ready=%b data=%h expected 1/%h", bus.mem_ready, bus.mem_rdata, exp); end
    tests_run++;
    if (proto_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL proto_drop_flag: got %b expected 1", proto_err); end
    @(negedge clk);
    tests_run++;
    if (bus.mem_ready !== 1'b0 || proto_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL proto_drop_after: got ready=%b err=%b expected 0/1", bus.mem_ready, proto_err); end
    exp = model_access(32'h10, 32'h0, 4'h0);
    do_txn(32'h10, 32'h0, 4'h0, 1'b0, rdata, lat, ra, st);
    tests_run++;
    if (proto_err !== 1'b1 || rdata !== exp) begin tests_failed++; $display("[TB] FAIL proto_sticky: got err=%b data=%h expected 1/%h", proto_err, rdata, exp); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rdata, exp;
    logic ra;
    int lat, st;
    exp = model_access(32'h20, 32'h11223344, 4'hF);
    do_txn(32'h20, 32'h11223344, 4'hF, 1'b0, rdata, lat, ra, st);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h20; bus.mem_wdata = 32'hAAAAAAAA; bus.mem_wstrb = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait_ready: got %b expected 0", bus.mem_ready); end
    reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_ready !== 1'b0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0 || proto_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait_state: got ready=%b rd=%0d wr=%0d err=%b expected 0/0/0/0", bus.mem_ready, rd_cnt, wr_cnt, proto_err); end
    exp = model_access(32'h20, 32'h0, 4'h0);
    do_txn(32'h20, 32'h0, 4'h0, 1'b0, rdata, lat, ra, st);
    tests_run++;
    if (rdata !== exp) begin tests_failed++; $display("[TB] FAIL rst_wait_nowrite: got %h expected %h", rdata, exp); end
    tests_run++;
    if (rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr)) begin tests_failed++; $display("[TB] FAIL rst_wait_counters: got rd=%0d wr=%0d expected %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr); end
  endtask

  task automatic test_proto_change();
    logic [31:0] rdata, exp;
    logic ra;
    int lat, st;
    exp = model_access(32'h30, 32'h0BADF00D, 4'hF);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h30; bus.mem_wdata = 32'h0BADF00D; bus.mem_wstrb = 4'hF;
    @(negedge clk);
    bus.mem_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    tests_run++;
    if (bus.mem_ready !== 1'b1 || proto_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL proto_change: got ready=%b err=%b expected 1/1", bus.mem_ready, proto_err); end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    exp = model_access(32'h30, 32'h0, 4'h0);
    do_txn(32'h30, 32'h0, 4'h0, 1'b0, rdata, lat, ra, st);
    tests_run++;
    if (rdata !== exp) begin tests_failed++; $display("[TB] FAIL proto_change_captured: got %h expected %h", rdata, exp); end
  endtask

  task automatic test_random();
    logic [31:0] rdata, exp, addr, wdata;
    logic [3:0] wstrb;
    logic ra;
    int lat, st, bad_lat, bad_data, bad_pulse;
    bad_lat = 0; bad_data = 0; bad_pulse = 0;
    for (int i = 0; i < 76; i++) begin
      addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wdata = $urandom;
      if (i < 16) begin
        addr  = (addr & ~32'h3C) | (32'(i) << 2);
        wstrb = 4'hF;
      end else begin
        wstrb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      end
      exp = model_access(addr, wdata, wstrb);
      do_txn(addr, wdata, wstrb, bit'($urandom_range(0, 1)), rdata, lat, ra, st);
      if (lat !== LATENCY) bad_lat++;
      if (rdata !== exp) begin
        bad_data++;
        if (bad_data <= 4) $display("[TB] op %0d addr=%h strb=%h data got %h expected %h", i, addr, wstrb, rdata, exp);
      end
      if (ra !== 1'b0) bad_pulse++;
    end
    bus.mem_valid = 1'b0;
    tests_run++;
    if (bad_lat != 0) begin tests_failed++; $display("[TB] FAIL rand_latency: got %0d bad ops expected 0", bad_lat); end
    tests_run++;
    if (bad_data != 0) begin tests_failed++; $display("[TB] FAIL rand_data: got %0d bad ops expected 0", bad_data); end
    tests_run++;
    if (bad_pulse != 0) begin tests_failed++; $display("[TB] FAIL rand_pulse: got %0d bad ops expected 0", bad_pulse); end
    tests_run++;
    if (rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr)) begin tests_failed++; $display("[TB] FAIL rand_counters: got rd=%0d wr=%0d expected %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_alias();
    test_back_to_back();
    test_proto_drop();
    test_reset_in_wait();
    test_proto_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
